// File: rtl/pipe_pkg.sv
// Shared bundle widths and field offsets for the pipeline stage registers.
// Every stage boundary instantiates pipe_stage_reg with the widths defined here.
package pipe_pkg;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 21;
    localparam int ID_EX_DATA_W  = 186;
    localparam int EX_MEM_CTRL_W = 10;
    localparam int EX_MEM_DATA_W = 106;
    localparam int MEM_WB_CTRL_W = 3;
    localparam int MEM_WB_DATA_W = 101;

    // ID/EX control bundle, LSB-first offsets
    localparam int CTRL_ALUSRC_LSB       = 0;
    localparam int CTRL_REGDST_LSB       = 1;
    localparam int CTRL_ALUOP_LSB        = 3;
    localparam int CTRL_JUMP_LSB         = 9;
    localparam int CTRL_BRANCH_LSB       = 10;
    localparam int CTRL_MEMREAD_LSB      = 11;
    localparam int CTRL_MEMWRITE_LSB     = 12;
    localparam int CTRL_SSEL_LSB         = 13;
    localparam int CTRL_LSEL_LSB         = 15;
    localparam int CTRL_WRITEDATASEL_LSB = 18;
    localparam int CTRL_MEMTOREG_LSB     = 19;
    localparam int CTRL_REGWRITE_LSB     = 20;

    // ID/EX data bundle, LSB-first offsets
    localparam int DATA_FUNCT_LSB   = 0;
    localparam int DATA_SHAMT_LSB   = 6;
    localparam int DATA_RD_ID_LSB   = 11;
    localparam int DATA_RT_ID_LSB   = 16;
    localparam int DATA_RS_ID_LSB   = 21;
    localparam int DATA_JTARGET_LSB = 26;
    localparam int DATA_PC4_LSB     = 58;
    localparam int DATA_IMM_LSB     = 90;
    localparam int DATA_RT_VAL_LSB  = 122;
    localparam int DATA_RS_VAL_LSB  = 154;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       write_data_sel;
        logic [2:0] lsel;
        logic [1:0] ssel;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic [5:0] alu_op;
        logic [1:0] reg_dst;
        logic       alu_src;
    } id_ex_ctrl_t;

    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t c);
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry holding register (valid + ctrl + data) used as the skid buffer.
// Clear drops the entry and zeroes ctrl; data is zeroed only when CLR_DATA=1.
module pipe_skid_slot import pipe_pkg::*; #(
    parameter int CTRL_W   = ID_EX_CTRL_W,
    parameter int DATA_W   = ID_EX_DATA_W,
    parameter int CLR_DATA = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (CLR_DATA != 0) r_data <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with stall, flush and a saturating kill counter.
// Define PIPE_SKID_EN to add a second (skid) entry and make in_ready independent of out_ready.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int CTRL_W         = ID_EX_CTRL_W,
    parameter int DATA_W         = ID_EX_DATA_W,
    parameter int FLUSH_CLR_DATA = 0,
    parameter int CNT_W          = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Flush,
    input  logic              Stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_acc;
    logic w_xfer;
    logic w_kill;

    assign w_acc  = in_valid && in_ready;
    assign w_xfer = r_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_clear;

    // Skid is only ever occupied while main is occupied, so main drains first.
    assign in_ready     = !Stall && !w_skid_valid;
    assign w_skid_load  = !Flush && w_acc && r_valid && !w_xfer;
    assign w_skid_clear = Flush || (w_xfer && w_skid_valid);
    assign w_kill       = r_valid || w_skid_valid;

    pipe_skid_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (FLUSH_CLR_DATA)
    ) u_skid (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (Flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (FLUSH_CLR_DATA != 0) r_data <= '0;
        end else if (w_xfer && w_skid_valid) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_skid_ctrl;
            r_data  <= w_skid_data;
        end else if (w_acc && (!r_valid || w_xfer)) begin
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_data  <= in_data;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end
`else
    assign in_ready = !Stall && (!r_valid || out_ready);
    assign w_kill   = r_valid;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (Flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (FLUSH_CLR_DATA != 0) r_data <= '0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_data  <= in_data;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_flush_cnt <= '0;
        end else if (Flush && w_kill && (r_flush_cnt != {CNT_W{1'b1}})) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_data  = r_data;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (base mode, or skid mode with PIPE_SKID_EN).
// A second small instance (CNT_W=2, FLUSH_CLR_DATA=1) covers counter saturation and data clearing.
module tb_pipe_stage_reg;

    localparam int CW = 21;
    localparam int DW = 186;

    logic          Clk = 1'b0;
    logic          Rst, Flush, Stall, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [15:0]   flush_cnt;

    logic          b_rst, b_flush, b_stall, b_in_valid, b_out_ready;
    logic          b_in_ready, b_out_valid;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [1:0]    b_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_CLR_DATA(0), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .Stall(Stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_CLR_DATA(1), .CNT_W(2)) dut_b (
        .Clk(Clk), .Rst(b_rst), .Flush(b_flush), .Stall(b_stall),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .flush_cnt(b_flush_cnt)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1; Flush = 0; Stall = 0; in_valid = 1; out_ready = 0;
        in_ctrl = 21'h5; in_data = 186'h7;
        b_rst = 1; b_flush = 0; b_stall = 0; b_in_valid = 1; b_out_ready = 0;
        b_in_ctrl = 21'h5; b_in_data = 186'h7;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_checks++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL reset_ctrl got %h want 0", out_ctrl); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        n_checks++; if (flush_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", flush_cnt); end
        n_checks++; if (b_flush_cnt !== 2'h0) begin n_fail++; $display("FAIL reset_cnt_b got %h want 0", b_flush_cnt); end
        Rst = 0; in_valid = 0; b_rst = 0; b_in_valid = 0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        out_ready = 1; in_valid = 1;
        for (int i = 1; i <= 8; i++) begin
            in_ctrl = CW'(i); in_data = DW'(i * 16);
            #1;
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); end
            n_checks++; if (out_ctrl !== CW'(i)) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %h want %h", i, out_ctrl, i); end
            n_checks++; if (out_data !== DW'(i * 16)) begin n_fail++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, i * 16); end
            $display("stream beat %0d ctrl=%h", i, out_ctrl);
        end
        in_valid = 0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1; in_ctrl = 21'h155; in_data = 186'h155;
        tick();
        in_ctrl = 21'h0AA; in_data = 186'h0AA;
        #1;
`ifdef PIPE_SKID_EN
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready got %b want 1", in_ready); end
`else
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
`endif
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 21'h155) begin n_fail++; $display("FAIL bp_hold got v=%b ctrl=%h want v=1 ctrl=155", out_valid, out_ctrl); end
        in_valid = 0; out_ready = 1;
        tick();
`ifdef PIPE_SKID_EN
        n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 21'h0AA) begin n_fail++; $display("FAIL bp_skid_order got v=%b ctrl=%h want v=1 ctrl=0aa", out_valid, out_ctrl); end
        tick();
`endif
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", out_valid); end
        $display("test_backpressure done");
    endtask

    task automatic test_stall();
        out_ready = 0; in_valid = 1; in_ctrl = 21'h33; in_data = 186'h33;
        tick();
        Stall = 1; in_ctrl = 21'h44; in_data = 186'h44;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 21'h33) begin n_fail++; $display("FAIL stall_hold got v=%b ctrl=%h want v=1 ctrl=33", out_valid, out_ctrl); end
        out_ready = 1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drain got %b want 0", out_valid); end
        Stall = 0; in_valid = 0;
        $display("test_stall done");
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_ctrl = 21'h1F; in_data = 186'hABCD;
        tick();
        in_valid = 0; Flush = 1;
        tick();
        Flush = 0; exp_cnt++;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", out_valid); end
        n_checks++; if (out_ctrl !== '0) begin n_fail++; $display("FAIL flush_ctrl got %h want 0", out_ctrl); end
        n_checks++; if (out_data !== 186'hABCD) begin n_fail++; $display("FAIL flush_data_hold got %h want abcd", out_data); end
        n_checks++; if (flush_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL flush_cnt got %h want %h", flush_cnt, exp_cnt); end
        Flush = 1;
        tick();
        Flush = 0;
        n_checks++; if (flush_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL flush_empty_cnt got %h want %h", flush_cnt, exp_cnt); end
        $display("test_flush done cnt=%0d", flush_cnt);
    endtask

    task automatic test_flush_accept();
        out_ready = 1; in_valid = 1; in_ctrl = 21'h77; in_data = 186'h77; Flush = 1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fa_in_ready got %b want 1", in_ready); end
        tick();
        Flush = 0; in_valid = 0;
        n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_fail++; $display("FAIL fa_dropped got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
        n_checks++; if (out_data !== 186'hABCD) begin n_fail++; $display("FAIL fa_data got %h want abcd", out_data); end
        n_checks++; if (flush_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL fa_cnt got %h want %h", flush_cnt, exp_cnt); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fa_next got %b want 0", out_valid); end
        // Stall together with flush: flush wins and kills the held entry
        out_ready = 0; in_valid = 1; in_ctrl = 21'h12; in_data = 186'h12;
        tick();
        in_valid = 0; Stall = 1; Flush = 1;
        tick();
        Stall = 0; Flush = 0; exp_cnt++;
        n_checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin n_fail++; $display("FAIL sf_kill got v=%b ctrl=%h want v=0 ctrl=0", out_valid, out_ctrl); end
        n_checks++; if (flush_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sf_cnt got %h want %h", flush_cnt, exp_cnt); end
        $display("test_flush_accept done cnt=%0d", flush_cnt);
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid_flush();
        out_ready = 0; in_valid = 1; in_ctrl = 21'h61; in_data = 186'h61;
        tick();
        in_ctrl = 21'h62; in_data = 186'h62;
        tick();
        in_valid = 0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_in_ready got %b want 0", in_ready); end
        Flush = 1;
        tick();
        Flush = 0; exp_cnt++;
        n_checks++; if (flush_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL skid_flush_cnt got %h want %h", flush_cnt, exp_cnt); end
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_flush_empty got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid); end
        out_ready = 1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL skid_flush_gone got %b want 0", out_valid); end
        $display("test_skid_flush done");
    endtask
`endif

    task automatic test_saturate();
        int exp_b;
        for (int k = 1; k <= 4; k++) begin
            b_in_valid = 1; b_in_ctrl = 21'h2A; b_in_data = 186'hABCD;
            tick();
            b_in_valid = 0; b_flush = 1;
            tick();
            b_flush = 0;
            exp_b = (k < 3) ? k : 3;
            n_checks++; if (b_flush_cnt !== 2'(exp_b)) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, b_flush_cnt, exp_b); end
            n_checks++; if (b_out_data !== '0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_clr[%0d] got v=%b data=%h want v=0 data=0", k, b_out_valid, b_out_data); end
            $display("saturate flush %0d cnt=%0d", k, b_flush_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_flush();
        test_flush_accept();
`ifdef PIPE_SKID_EN
        test_skid_flush();
`endif
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
